// File: rtl/switch_reader_pkg.sv
// Shared definitions for the switch operand reader.
//   state_t             : top-level sequencing states
//   NUM_SW_BITS         : raw switch bits handled (two 2-bit banks)
//   *_DEF               : default timing/width parameters (48 MHz HFOSC, 10 ms)
package switch_reader_pkg;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam int NUM_SW_BITS         = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 480000;
  localparam int CNT_W_DEF           = 19;
  localparam int SYNC_STAGES_DEF     = 2;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: synchroniser chain, debounce counter and committed flop.
//   clk, rst   : clock, async active-high reset
//   raw        : asynchronous switch input
//   en         : debounce counting enabled (top is in S_RUN)
//   load       : force committed to the synchronised value (initial load)
//   sync_next  : value the synchronised bit takes at the next edge
//   sync_bit   : synchronised bit
//   committed  : debounced value
//   commit     : high in the cycle committed will flip at the next edge
//   cnt_nz     : debounce counter is non-zero
module debounce_bit
  import switch_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic en,
  input  logic load,
  output logic sync_next,
  output logic sync_bit,
  output logic committed,
  output logic commit,
  output logic cnt_nz
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic [CNT_W-1:0]       cnt;
  logic                   differs;

  assign sync_bit  = sync_ff[SYNC_STAGES-1];
  assign sync_next = sync_ff[SYNC_STAGES-2];
  assign differs   = sync_bit != committed;
  assign commit    = en && differs && (cnt == TERM);
  assign cnt_nz    = cnt != '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], raw};
    end
  end

  // Counter restarts whenever the input returns to the committed value,
  // and wraps to zero on the commit itself, so it never passes TERM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || !differs || cnt == TERM) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      committed <= 1'b0;
    end else if (load || commit) begin
      committed <= sync_bit;
    end
  end

endmodule

// File: rtl/switch_operand_reader.sv
// Debounced operand front end for the switch-driven comparator.
//   clk, rst       : clock, async active-high reset
//   sw1_raw        : raw switch bank 1 -> operand b
//   sw2_raw        : raw switch bank 2 -> operand a
//   a_out, b_out   : debounced operands (registered)
//   operands_valid : startup window done, held until reset
//   update_stb     : one-cycle pulse whenever a_out/b_out take a new value
//   busy           : startup in progress or any bit mid-debounce
//
// state  | meaning
// S_INIT | waiting for all synchronised inputs to sit still for a full window
// S_LOAD | one cycle: copy synchronised inputs into committed bits, strobe
// S_RUN  | per-bit debouncing active
module switch_operand_reader
  import switch_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sw1_raw,
  input  logic [1:0] sw2_raw,
  output logic [1:0] a_out,
  output logic [1:0] b_out,
  output logic       operands_valid,
  output logic       update_stb,
  output logic       busy
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        init_cnt;
  logic [NUM_SW_BITS-1:0]  raw, s, s_next, committed, commit, cnt_nz;
  logic                    s_change;
  logic                    en, load;

  assign raw  = {sw2_raw, sw1_raw};
  assign en   = state_q == S_RUN;
  assign load = state_q == S_LOAD;

  for (genvar i = 0; i < NUM_SW_BITS; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_bit (
      .clk       (clk),
      .rst       (rst),
      .raw       (raw[i]),
      .en        (en),
      .load      (load),
      .sync_next (s_next[i]),
      .sync_bit  (s[i]),
      .committed (committed[i]),
      .commit    (commit[i]),
      .cnt_nz    (cnt_nz[i])
    );
  end

  // Change is detected on the edge where s itself moves, so the cycle that
  // first shows a new value already counts toward the stable window.
  assign s_change = s_next != s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (!s_change && init_cnt == TERM) state_d = S_LOAD;
      S_LOAD:  state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_cnt <= '0;
    end else if (state_q == S_INIT && !s_change && init_cnt != TERM) begin
      init_cnt <= init_cnt + 1'b1;
    end else begin
      init_cnt <= '0;
    end
  end

  // Committed flops are the output registers; the strobe is registered
  // alongside them so it lines up with the cycle the new value appears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      update_stb     <= 1'b0;
      operands_valid <= 1'b0;
    end else begin
      update_stb <= load || (|commit);
      if (load) operands_valid <= 1'b1;
    end
  end

  assign a_out = committed[3:2];
  assign b_out = committed[1:0];
  assign busy  = (state_q != S_RUN) || (|cnt_nz);

endmodule

// File: tb/tb_switch_operand_reader.sv
module tb_switch_operand_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sw1_raw = 2'b10;
  logic [1:0] sw2_raw = 2'b01;
  logic [1:0] a_out, b_out;
  logic       operands_valid, update_stb, busy;

  int checks = 0;
  int errors = 0;
  int stb_cnt = 0;
  int exp_stb = 0;

  switch_operand_reader #(
    .DEBOUNCE_CYCLES (8),
    .CNT_W           (4),
    .SYNC_STAGES     (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sw1_raw        (sw1_raw),
    .sw2_raw        (sw2_raw),
    .a_out          (a_out),
    .b_out          (b_out),
    .operands_valid (operands_valid),
    .update_stb     (update_stb),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && update_stb) stb_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // reset with sw1=10, sw2=01 held
    step(3);
    chk("rst_a", 32'(a_out), 32'd0);
    chk("rst_b", 32'(b_out), 32'd0);
    chk("rst_valid", 32'(operands_valid), 32'd0);
    chk("rst_stb", 32'(update_stb), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    step(10);
    chk("init_valid_e10", 32'(operands_valid), 32'd0);
    chk("init_stb_e10", 32'(update_stb), 32'd0);
    step(1);
    chk("init_valid_e11", 32'(operands_valid), 32'd1);
    chk("init_stb_e11", 32'(update_stb), 32'd1);
    chk("init_a", 32'(a_out), 32'h1);
    chk("init_b", 32'(b_out), 32'h2);
    chk("init_busy", 32'(busy), 32'd0);
    exp_stb = 1;
    step(20);
    chk("init_stb_count", 32'(stb_cnt), 32'(exp_stb));

    // clean change of operand a
    sw2_raw = 2'b11;
    step(5);
    chk("clean_busy", 32'(busy), 32'd1);
    step(4);
    chk("clean_a_e9", 32'(a_out), 32'h1);
    chk("clean_stb_e9", 32'(update_stb), 32'd0);
    step(1);
    chk("clean_a_e10", 32'(a_out), 32'h3);
    chk("clean_b_e10", 32'(b_out), 32'h2);
    chk("clean_stb_e10", 32'(update_stb), 32'd1);
    exp_stb++;
    step(1);
    chk("clean_stb_e11", 32'(update_stb), 32'd0);
    chk("clean_busy_done", 32'(busy), 32'd0);

    // 7-cycle glitch on sw1[0] must not commit
    sw1_raw = 2'b11;
    step(5);
    chk("glitch_busy", 32'(busy), 32'd1);
    step(2);
    sw1_raw = 2'b10;
    step(10);
    chk("glitch_b", 32'(b_out), 32'h2);
    chk("glitch_a", 32'(a_out), 32'h3);
    chk("glitch_busy_after", 32'(busy), 32'd0);
    chk("glitch_stb_count", 32'(stb_cnt), 32'(exp_stb));

    // simultaneous change on both banks
    sw1_raw = 2'b00;
    sw2_raw = 2'b10;
    step(9);
    chk("sim_a_e9", 32'(a_out), 32'h3);
    chk("sim_b_e9", 32'(b_out), 32'h2);
    step(1);
    chk("sim_a_e10", 32'(a_out), 32'h2);
    chk("sim_b_e10", 32'(b_out), 32'h0);
    chk("sim_stb_e10", 32'(update_stb), 32'd1);
    exp_stb++;
    step(5);
    chk("sim_stb_count", 32'(stb_cnt), 32'(exp_stb));

    // reset while sw1[0] is mid-debounce (cnt = 5 after edge 7)
    sw1_raw = 2'b01;
    step(7);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_b_unchanged", 32'(b_out), 32'h0);
    rst = 1'b1;
    #1;
    chk("mid_rst_a", 32'(a_out), 32'd0);
    chk("mid_rst_b", 32'(b_out), 32'd0);
    chk("mid_rst_valid", 32'(operands_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd1);
    step(2);
    rst = 1'b0;
    step(10);
    chk("mid_valid_e10", 32'(operands_valid), 32'd0);
    step(1);
    chk("mid_valid_e11", 32'(operands_valid), 32'd1);
    chk("mid_stb_e11", 32'(update_stb), 32'd1);
    chk("mid_a", 32'(a_out), 32'h2);
    chk("mid_b", 32'(b_out), 32'h1);
    exp_stb++;
    step(3);
    chk("mid_stb_count", 32'(stb_cnt), 32'(exp_stb));

    // startup bounce on sw2[1]
    rst = 1'b1;
    sw1_raw = 2'b00;
    sw2_raw = 2'b10;
    step(2);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      sw2_raw[1] = ~sw2_raw[1];
      for (int j = 0; j < 3; j++) begin
        step(1);
        chk("bounce_valid", 32'(operands_valid), 32'd0);
      end
    end
    // last toggle was three edges ago; load lands eleven edges after it
    step(7);
    chk("bounce_valid_e10", 32'(operands_valid), 32'd0);
    chk("bounce_stb_e10", 32'(update_stb), 32'd0);
    step(1);
    chk("bounce_valid_e11", 32'(operands_valid), 32'd1);
    chk("bounce_stb_e11", 32'(update_stb), 32'd1);
    chk("bounce_a", 32'(a_out), 32'h2);
    chk("bounce_b", 32'(b_out), 32'h0);
    exp_stb++;
    step(5);
    chk("bounce_stb_count", 32'(stb_cnt), 32'(exp_stb));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
